dma_irq_coalescer: RTL and testbench

- Completion-side stage downstream of the DMA core wrapper.
- Consumes the per-job completion stream (frontend/midend response valid) and job-issue handshakes.
- Tracks outstanding and completed-but-unacknowledged jobs, and raises one coalesced interrupt to the CPU.
- Interrupt fires on a completion-count threshold, a timeout, or an error.

---
 rtl/dma_irq_coalescer.sv | 119 +++++++++++
 tb/tb_dma_irq_coalescer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/dma_irq_coalescer.sv
// rtl/dma_irq_coalescer.sv - DMA completion interrupt coalescer
// Tracks issued/completed jobs and raises one interrupt per batch, timeout or error.
module dma_irq_coalescer #(
    parameter int CntWidth   = 16,
    parameter int TimerWidth = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  issue_valid_i,
    output logic                  issue_ready_o,
    input  logic                  done_valid_i,
    input  logic                  done_error_i,
    output logic                  done_ready_o,
    input  logic                  cfg_enable_i,
    input  logic [CntWidth-1:0]   cfg_threshold_i,
    input  logic [TimerWidth-1:0] cfg_timeout_i,
    input  logic                  ack_valid_i,
    input  logic [CntWidth-1:0]   ack_count_i,
    input  logic                  error_clear_i,
    output logic                  irq_o,
    output logic [CntWidth-1:0]   pending_o,
    output logic [CntWidth-1:0]   outstanding_o,
    output logic                  error_o,
    output logic                  underflow_o,
    output logic                  idle_o
);

    typedef enum logic [1:0] {IDLE, COLLECT, FIRE} state_t;

    localparam logic [CntWidth-1:0] CntMax = '1;
    localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

    state_t                state, state_next;
    logic [CntWidth-1:0]   outstanding, pending, pending_next, ack_eff, thr;
    logic [TimerWidth-1:0] timer;
    logic                  irq, error, underflow;
    logic                  issue_fire, done_fire, err_done, retire, timeout, hit;

    assign issue_ready_o = (outstanding != CntMax);
    assign ack_eff       = !ack_valid_i ? '0 :
                           (ack_count_i < pending) ? ack_count_i : pending;
    assign done_ready_o  = (pending != CntMax) || (ack_eff != '0);
    assign issue_fire    = issue_valid_i & issue_ready_o;
    assign done_fire     = done_valid_i & done_ready_o;
    assign err_done      = done_fire & done_error_i;

    // With nothing outstanding, a completion only retires the job issued in the same cycle.
    assign retire        = done_fire & ((outstanding != '0) | issue_fire);

    assign pending_next  = pending + (done_fire ? CntOne : '0) - ack_eff;
    assign thr           = (cfg_threshold_i == '0) ? CntOne : cfg_threshold_i;
    assign timeout       = (state == COLLECT) && (cfg_timeout_i != '0) &&
                           (timer == cfg_timeout_i - TimerWidth'(1));
    assign hit           = (pending_next >= thr) || err_done || timeout;

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (hit)            state_next = FIRE;
                else if (done_fire) state_next = COLLECT;
            end
            COLLECT: begin
                if (pending_next == '0) state_next = IDLE;
                else if (hit)           state_next = FIRE;
            end
            FIRE: begin
                if (pending_next == '0)
                    state_next = IDLE;
                else if (ack_valid_i && (pending_next < thr) && !err_done)
                    state_next = COLLECT;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            timer       <= '0;
            outstanding <= '0;
            pending     <= '0;
            irq         <= 1'b0;
            error       <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            state   <= state_next;
            pending <= pending_next;
            // Driven from the next state so a threshold hit shows on the following cycle.
            irq     <= (state_next == FIRE) & cfg_enable_i;

            if (issue_fire && !retire)
                outstanding <= outstanding + CntOne;
            else if (!issue_fire && retire)
                outstanding <= outstanding - CntOne;

            if (done_fire && (outstanding == '0) && !issue_fire)
                underflow <= 1'b1;

            if (err_done)
                error <= 1'b1;
            else if (error_clear_i)
                error <= 1'b0;

            if ((state_next == COLLECT) && (state != COLLECT))
                timer <= '0;
            else if ((state == COLLECT) && (timer != '1))
                timer <= timer + TimerWidth'(1);
        end
    end

    assign irq_o         = irq;
    assign pending_o     = pending;
    assign outstanding_o = outstanding;
    assign error_o       = error;
    assign underflow_o   = underflow;
    assign idle_o        = (outstanding == '0) && (pending == '0);

endmodule

// File: tb/tb_dma_irq_coalescer.sv
// tb/tb_dma_irq_coalescer.sv - directed scoreboard bench for dma_irq_coalescer
module tb_dma_irq_coalescer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance, default widths
    logic        rst, issue_valid, done_valid, done_error, cfg_enable, ack_valid, error_clear;
    logic [15:0] cfg_threshold, cfg_timeout, ack_count;
    logic        issue_ready, done_ready, irq, error, underflow, idle;
    logic [15:0] pending, outstanding;

    dma_irq_coalescer dut (
        .clk_i(clk), .rst_i(rst),
        .issue_valid_i(issue_valid), .issue_ready_o(issue_ready),
        .done_valid_i(done_valid), .done_error_i(done_error), .done_ready_o(done_ready),
        .cfg_enable_i(cfg_enable), .cfg_threshold_i(cfg_threshold), .cfg_timeout_i(cfg_timeout),
        .ack_valid_i(ack_valid), .ack_count_i(ack_count), .error_clear_i(error_clear),
        .irq_o(irq), .pending_o(pending), .outstanding_o(outstanding),
        .error_o(error), .underflow_o(underflow), .idle_o(idle)
    );

    // Narrow instance for saturation behaviour
    logic        s_rst, s_issue, s_done, s_ack;
    logic [1:0]  s_thr, s_ack_count;
    logic [15:0] s_timeout;
    logic        s_issue_ready, s_done_ready, s_irq, s_error, s_underflow, s_idle;
    logic [1:0]  s_pending, s_outstanding;

    dma_irq_coalescer #(.CntWidth(2), .TimerWidth(16)) dut_small (
        .clk_i(clk), .rst_i(s_rst),
        .issue_valid_i(s_issue), .issue_ready_o(s_issue_ready),
        .done_valid_i(s_done), .done_error_i(1'b0), .done_ready_o(s_done_ready),
        .cfg_enable_i(1'b1), .cfg_threshold_i(s_thr), .cfg_timeout_i(s_timeout),
        .ack_valid_i(s_ack), .ack_count_i(s_ack_count), .error_clear_i(1'b0),
        .irq_o(s_irq), .pending_o(s_pending), .outstanding_o(s_outstanding),
        .error_o(s_error), .underflow_o(s_underflow), .idle_o(s_idle)
    );

    int          n_asrt = 0;
    int          n_fail = 0;
    string       tag_q[$];
    logic [31:0] exp_q[$];

    task automatic want(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic got(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        n_asrt++;
        assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %0h expected an entry", obs);
        end
        if (exp_q.size() != 0) begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", t, obs, e);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; issue_valid = 0; done_valid = 0; done_error = 0; cfg_enable = 1;
        ack_valid = 0; error_clear = 0; cfg_threshold = 4; cfg_timeout = 0; ack_count = 0;
        s_rst = 1; s_issue = 0; s_done = 0; s_ack = 0; s_thr = 3; s_ack_count = 0; s_timeout = 0;
        step(); step();
        rst = 0; s_rst = 0;

        want("rst_irq", 0); want("rst_pending", 0); want("rst_outstanding", 0);
        want("rst_idle", 1); want("rst_issue_ready", 1); want("rst_done_ready", 1);
        want("rst_error", 0); want("rst_underflow", 0);
        want("rst_s_irq", 0); want("rst_s_error", 0); want("rst_s_idle", 1);
        got(irq); got(pending); got(outstanding); got(idle); got(issue_ready);
        got(done_ready); got(error); got(underflow); got(s_irq); got(s_error); got(s_idle);

        // Threshold batch of 4
        issue_valid = 1;
        repeat (4) step();
        issue_valid = 0;
        want("t1_outstanding", 4); got(outstanding);
        done_valid = 1;
        repeat (3) step();
        want("t1_irq_early", 0); want("t1_pending3", 3); got(irq); got(pending);
        step();
        done_valid = 0;
        want("t1_irq", 1); want("t1_pending", 4); want("t1_outstanding0", 0);
        got(irq); got(pending); got(outstanding);
        ack_valid = 1; ack_count = 4;
        step();
        ack_valid = 0;
        want("t1_ack_irq", 0); want("t1_ack_idle", 1); want("t1_ack_pending", 0);
        got(irq); got(idle); got(pending);

        // Timeout with simultaneous issue+done at outstanding 0
        cfg_threshold = 8; cfg_timeout = 10;
        issue_valid = 1; done_valid = 1;
        step();
        issue_valid = 0; done_valid = 0;
        want("t2_irq0", 0); want("t2_outstanding", 0); want("t2_underflow", 0);
        got(irq); got(outstanding); got(underflow);
        repeat (9) step();
        want("t2_irq_before_timeout", 0); got(irq);
        step();
        want("t2_irq_timeout", 1); want("t2_pending", 1); got(irq); got(pending);
        ack_valid = 1; ack_count = 1;
        step();
        ack_valid = 0;
        want("t2_ack_irq", 0); want("t2_ack_idle", 1); got(irq); got(idle);

        // Partial acks in FIRE
        cfg_threshold = 4; cfg_timeout = 0;
        issue_valid = 1; done_valid = 1;
        repeat (6) step();
        issue_valid = 0; done_valid = 0;
        want("t3_pending6", 6); want("t3_irq6", 1); got(pending); got(irq);
        ack_valid = 1; ack_count = 1;
        step();
        want("t3_pending5", 5); want("t3_irq5", 1); got(pending); got(irq);
        ack_count = 3;
        step();
        want("t3_pending2", 2); want("t3_irq2", 0); got(pending); got(irq);
        ack_count = 5;
        step();
        ack_valid = 0;
        want("t3_pending_clamp", 0); want("t3_idle", 1); want("t3_irq_idle", 0);
        got(pending); got(idle); got(irq);

        // Error completion and set-wins-over-clear
        cfg_threshold = 16;
        issue_valid = 1; done_valid = 1; done_error = 1;
        step();
        want("t4_irq", 1); want("t4_error", 1); want("t4_pending", 1);
        got(irq); got(error); got(pending);
        error_clear = 1;
        step();
        issue_valid = 0; done_valid = 0; done_error = 0;
        want("t4_error_set_wins", 1); want("t4_irq_kept", 1); want("t4_pending2", 2);
        got(error); got(irq); got(pending);
        step();
        error_clear = 0;
        want("t4_error_cleared", 0); got(error);
        ack_valid = 1; ack_count = 2;
        step();
        ack_valid = 0;
        want("t4_ack_irq", 0); want("t4_ack_pending", 0); got(irq); got(pending);

        // Enable masking and mid-operation reset
        cfg_threshold = 1; cfg_enable = 0;
        issue_valid = 1; done_valid = 1;
        step();
        issue_valid = 0; done_valid = 0;
        want("t6_irq_masked", 0); want("t6_pending", 1); got(irq); got(pending);
        cfg_enable = 1;
        step();
        want("t6_irq_enabled", 1); got(irq);
        issue_valid = 1;
        step();
        issue_valid = 0;
        want("t6_outstanding", 1); got(outstanding);
        rst = 1;
        step();
        rst = 0;
        want("t6_rst_irq", 0); want("t6_rst_pending", 0); want("t6_rst_outstanding", 0);
        want("t6_rst_idle", 1);
        got(irq); got(pending); got(outstanding); got(idle);

        // Narrow counters: underflow, issue stall, done stall
        s_done = 1;
        step();
        s_done = 0;
        want("s_underflow", 1); want("s_outstanding0", 0); want("s_pending1", 1);
        got(s_underflow); got(s_outstanding); got(s_pending);
        s_issue = 1;
        repeat (3) step();
        want("s_outstanding3", 3); want("s_issue_ready0", 0);
        got(s_outstanding); got(s_issue_ready);
        step();
        s_issue = 0;
        want("s_outstanding_held", 3); got(s_outstanding);
        s_done = 1;
        repeat (2) step();
        want("s_pending3", 3); want("s_outstanding1", 1); want("s_done_ready0", 0);
        got(s_pending); got(s_outstanding); got(s_done_ready);
        step();
        want("s_pending_stalled", 3); want("s_outstanding_stalled", 1);
        got(s_pending); got(s_outstanding);
        s_ack = 1; s_ack_count = 1;
        #1;
        want("s_done_ready_ack", 1); got(s_done_ready);
        step();
        s_ack = 0; s_done = 0;
        want("s_pending_ack", 3); want("s_outstanding_ack", 0);
        got(s_pending); got(s_outstanding);

        n_asrt++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_leftover: observed %0d expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
